// File: rtl/gate_bist_pkg.sv
// +----------------------------------------------------------------------+
// | gate_bist_pkg : shared types and constants for the gate BIST block   |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
`default_nettype none

package gate_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_WAIT   = 3'd2,
    S_SAMPLE = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  // Gray order so exactly one stimulus line toggles per step.
  localparam logic [1:0] VEC [0:3] = '{2'b00, 2'b01, 2'b11, 2'b10};

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_XOR  = 4'b0110;

  function automatic logic [1:0] vec_of(input logic [1:0] idx);
    return VEC[idx];
  endfunction

endpackage

`default_nettype wire

// File: rtl/gate_bist_settle_cnt.sv
// +----------------------------------------------------------------------+
// | gate_bist_settle_cnt : loadable saturating down-counter              |
// | Revision             : 1.0                                           |
// +----------------------------------------------------------------------+
`default_nettype none

module gate_bist_settle_cnt #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [CW-1:0] val_i,
  output logic          zero_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/gate_bist_seq.sv
// +----------------------------------------------------------------------+
// | gate_bist_seq : Gray-order truth-table BIST sequencer for 2-in cells |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module gate_bist_seq
  import gate_bist_pkg::*;
#(
  parameter int N_GATES = 4,
  parameter int SETTLE  = 2,
  parameter int CW      = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [4*N_GATES-1:0]   tt_i,
  input  logic [N_GATES-1:0]     y_i,
  output logic                   a_o,
  output logic                   b_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [N_GATES-1:0]     fail_mask_o,
  output logic [1:0]             fail_vec_o
);

  state_t state_q, state_d;

  logic                      a_q, a_d;
  logic                      b_q, b_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      pass_q, pass_d;
  logic [N_GATES-1:0]        mask_q, mask_d;
  logic [1:0]                fvec_q, fvec_d;
  logic [1:0]                idx_q, idx_d;
  logic [N_GATES-1:0][3:0]   tt_q, tt_d;

  logic [1:0]                cur_vec;
  logic [N_GATES-1:0]        exp_bits;
  logic [N_GATES-1:0]        mismatch;
  logic                      cnt_load;
  logic                      cnt_zero;

  // Counter is loaded on entry to APPLY, so it holds SETTLE during APPLY
  // and reaches zero on the last WAIT cycle.
  assign cnt_load = (state_d == S_APPLY);

  gate_bist_settle_cnt #(
    .CW (CW)
  ) u_settle_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (cnt_load),
    .val_i  (CW'(SETTLE)),
    .zero_o (cnt_zero)
  );

  always_comb begin
    cur_vec  = vec_of(idx_q);
    exp_bits = '0;
    for (int g = 0; g < N_GATES; g++) begin
      exp_bits[g] = tt_q[g][cur_vec];
    end
    mismatch = y_i ^ exp_bits;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = S_APPLY;
      S_APPLY:  state_d = (SETTLE > 0) ? S_WAIT : S_SAMPLE;
      S_WAIT:   if (cnt_zero) state_d = S_SAMPLE;
      S_SAMPLE: state_d = (idx_q == 2'd3) ? S_FINISH : S_APPLY;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output registers are driven from the next state so every output is
  // valid in the same cycle as the state it belongs to.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    busy_d = busy_q;
    done_d = 1'b0;
    pass_d = pass_q;
    mask_d = mask_q;
    fvec_d = fvec_q;
    idx_d  = idx_q;
    tt_d   = tt_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          tt_d   = tt_i;
          mask_d = '0;
          fvec_d = 2'b00;
          pass_d = 1'b0;
          idx_d  = 2'd0;
        end
      end
      S_SAMPLE: begin
        mask_d = mask_q | mismatch;
        if ((mismatch != '0) && (mask_q == '0)) begin
          fvec_d = cur_vec;
        end
        if (idx_q != 2'd3) begin
          idx_d = idx_q + 2'd1;
        end
      end
      default: ;
    endcase

    if (state_d == S_APPLY) begin
      {a_d, b_d} = vec_of(idx_d);
      busy_d     = 1'b1;
    end
    if (state_d == S_FINISH) begin
      done_d = 1'b1;
      busy_d = 1'b0;
      pass_d = (mask_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      mask_q <= '0;
      fvec_q <= 2'b00;
      idx_q  <= 2'd0;
      tt_q   <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
      mask_q <= mask_d;
      fvec_q <= fvec_d;
      idx_q  <= idx_d;
      tt_q   <= tt_d;
    end
  end

  assign a_o         = a_q;
  assign b_o         = b_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign fail_mask_o = mask_q;
  assign fail_vec_o  = fvec_q;

endmodule

`default_nettype wire

// File: tb/tb_gate_bist_seq.sv
// +----------------------------------------------------------------------+
// | tb_gate_bist_seq : self-checking bench for gate_bist_seq             |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_gate_bist_seq;
  import gate_bist_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] tt;
  logic [1:0]  start_v;
  logic [3:0]  sa0, sa1;

  logic       a_w    [2];
  logic       b_w    [2];
  logic       busy_w [2];
  logic       done_w [2];
  logic       pass_w [2];
  logic [3:0] mask_w [2];
  logic [1:0] fvec_w [2];
  logic [3:0] y_w    [2];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gate_bist_seq #(.N_GATES(4), .SETTLE(2), .CW(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start_v[0]), .tt_i(tt), .y_i(y_w[0]),
    .a_o(a_w[0]), .b_o(b_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0]),
    .pass_o(pass_w[0]), .fail_mask_o(mask_w[0]), .fail_vec_o(fvec_w[0])
  );

  gate_bist_seq #(.N_GATES(4), .SETTLE(0), .CW(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start_v[1]), .tt_i(tt), .y_i(y_w[1]),
    .a_o(a_w[1]), .b_o(b_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1]),
    .pass_o(pass_w[1]), .fail_mask_o(mask_w[1]), .fail_vec_o(fvec_w[1])
  );

  // Cell g: 0=AND 1=OR 2=NAND 3=XOR, with optional stuck-at faults.
  function automatic logic cell_out(input int g, input logic a, input logic b,
                                    input logic [3:0] s0, input logic [3:0] s1);
    logic y;
    case (g)
      0:       y = a & b;
      1:       y = a | b;
      2:       y = ~(a & b);
      default: y = a ^ b;
    endcase
    if (s0[g]) y = 1'b0;
    if (s1[g]) y = 1'b1;
    return y;
  endfunction

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      y_w[d] = '0;
      for (int g = 0; g < 4; g++) begin
        y_w[d][g] = cell_out(g, a_w[d], b_w[d], sa0, sa1);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walks the four Gray vectors and collects the expected run outcome.
  task automatic model(input logic [15:0] t, input logic [3:0] s0, input logic [3:0] s1,
                       output logic [3:0] m, output logic [1:0] fv);
    int v;
    logic [3:0] mm;
    m  = '0;
    fv = 2'b00;
    for (int i = 0; i < 4; i++) begin
      v  = i ^ (i >> 1);
      mm = '0;
      for (int g = 0; g < 4; g++) begin
        if (cell_out(g, v[1], v[0], s0, s1) != t[4*g + v]) mm[g] = 1'b1;
      end
      if (mm != 0 && m == 0) fv = 2'(v);
      m = m | mm;
    end
  endtask

  task automatic chk_result(input int d, input logic [15:0] t);
    logic [3:0] m;
    logic [1:0] fv;
    model(t, sa0, sa1, m, fv);
    chk("fail_mask", 32'(mask_w[d]), 32'(m));
    chk("fail_vec", 32'(fvec_w[d]), 32'(fv));
    chk("pass", 32'(pass_w[d]), 32'(m == 0));
  endtask

  // Starts at posedge+1 (cycle 0 = START cycle) and ends at posedge+1.
  task automatic run_once(input int d, input int s, input int poke_a, input int poke_b,
                          input int tt_cyc, input logic [15:0] tt_new);
    int P, last, idx;
    logic [1:0] exp_ab;
    P    = s + 2;
    last = 4 * P + 1;
    start_v[d] = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= last + 2; k++) begin
      start_v[d] = (k == poke_a) || (k == poke_b);
      if (k == tt_cyc) tt = tt_new;
      @(negedge clk);
      if (k < last) begin
        idx    = (k - 1) / P;
        exp_ab = 2'(idx ^ (idx >> 1));
        chk("pass_cleared", 32'(pass_w[d]), 32'd0);
      end else begin
        exp_ab = 2'b10;
      end
      chk($sformatf("ab_c%0d", k), 32'({a_w[d], b_w[d]}), 32'(exp_ab));
      chk($sformatf("busy_c%0d", k), 32'(busy_w[d]), 32'(k < last));
      chk($sformatf("done_c%0d", k), 32'(done_w[d]), 32'(k == last));
      @(posedge clk); #1;
    end
    start_v[d] = 1'b0;
  endtask

  initial begin
    logic [15:0] tt_ref, tt_used;
    rst_n   = 1'b0;
    start_v = 2'b00;
    sa0     = '0;
    sa1     = '0;
    tt_ref  = {TT_XOR, TT_NAND, TT_OR, TT_AND};
    tt      = tt_ref;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ab", 32'({a_w[0], b_w[0]}), 32'd0);
    chk("rst_busy", 32'(busy_w[0]), 32'd0);
    chk("rst_done", 32'(done_w[0]), 32'd0);
    chk("rst_pass", 32'(pass_w[0]), 32'd0);
    chk("rst_mask", 32'(mask_w[0]), 32'd0);
    chk("rst_fvec", 32'(fvec_w[0]), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Good cells, SETTLE=2
    run_once(0, 2, 0, 0, 0, '0);
    chk_result(0, tt_ref);

    // OR cell stuck-at-0
    sa0 = 4'b0010;
    run_once(0, 2, 0, 0, 0, '0);
    chk_result(0, tt_ref);
    sa0 = '0;

    // SETTLE=0 instance
    run_once(1, 0, 0, 0, 0, '0);
    chk_result(1, tt_ref);

    // START re-pulsed during the run is ignored
    run_once(0, 2, 3, 10, 0, '0);
    chk_result(0, tt_ref);

    // Asynchronous reset mid-run
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_ab", 32'({a_w[0], b_w[0]}), 32'd0);
    chk("arst_busy", 32'(busy_w[0]), 32'd0);
    chk("arst_done", 32'(done_w[0]), 32'd0);
    chk("arst_mask", 32'(mask_w[0]), 32'd0);
    chk("arst_pass", 32'(pass_w[0]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(done_w[0]), 32'd0);
      chk("post_rst_busy", 32'(busy_w[0]), 32'd0);
    end
    @(posedge clk); #1;
    run_once(0, 2, 0, 0, 0, '0);
    chk_result(0, tt_ref);

    // TT change mid-run has no effect; next run uses the new TT
    run_once(0, 2, 0, 0, 5, 16'h0000);
    chk_result(0, tt_ref);
    run_once(0, 2, 0, 0, 0, '0);
    chk_result(0, 16'h0000);
    chk("zero_tt_mask", 32'(mask_w[0]), 32'hF);

    // Randomized truth tables and faults on both instances
    for (int it = 0; it < 8; it++) begin
      tt_used = 16'($urandom);
      tt      = tt_used;
      sa0     = 4'($urandom) & 4'($urandom);
      sa1     = ~sa0 & 4'($urandom) & 4'($urandom);
      if (it % 3 == 0) tt = tt_ref;
      tt_used = tt;
      run_once(it % 2, (it % 2 == 1) ? 0 : 2, 0, 0, 0, '0);
      chk_result(it % 2, tt_used);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gate_bist_seq.md
Name: gate_bist_seq

Overview:
- Built-in self-test sequencer for a bank of N_GATES two-input standard cells (AND2X1, OR2X1, NAND2X1, XOR2X1, ...) instantiated on a test chip.
- Drives a shared A/B stimulus bus through all four input combinations in Gray order.
- After a programmable settle time, samples each cell's Y output and checks it against a per-cell expected truth table.
- Reports pass/fail, a per-cell fail mask and the first failing vector; sits between the chip test-control register block and the cell bank.

Parameters:
N_GATES, 4, number of cells under test sharing the A_OUT/B_OUT bus
SETTLE, 2, idle cycles between applying a vector and sampling Y (0 allowed)
CW, 4, settle counter width; SETTLE < 2**CW

Ports:
CLK  input  1  clock, rising edge
R  input  1  asynchronous active-low reset
START  input  1  run request, sampled only in IDLE
TT  input  4*N_GATES  expected truth tables; TT[4*g+{A,B}] = expected Y of cell g
Y_IN  input  N_GATES  outputs of cells under test
A_OUT  output  1  stimulus A to all cells
B_OUT  output  1  stimulus B to all cells
BUSY  output  1  high from the cycle after START acceptance until DONE
DONE  output  1  one-cycle completion pulse
PASS  output  1  result of last run; valid from DONE until next START acceptance
FAIL_MASK  output  N_GATES  bit g set if cell g mismatched on any vector
FAIL_VEC  output  2  {A,B} of first mismatching vector; 0 if none

Behaviour:
- Reset (R low, asynchronous): state IDLE; A_OUT=B_OUT=0, BUSY=0, DONE=0, PASS=0, FAIL_MASK=0, FAIL_VEC=0, vector index=0, settle count=0. Reset mid-run aborts immediately; no DONE is produced.
- All outputs are registered; no combinational path from inputs to outputs.
- Vector sequence (index 0..3, {A,B}): 00, 01, 11, 10, so exactly one input toggles per step.
- States: IDLE, APPLY, WAIT, SAMPLE, FINISH.
- IDLE:
  - START=1 latches TT into an internal copy, clears FAIL_MASK, FAIL_VEC and PASS, sets index=0, and goes to APPLY.
  - Otherwise the state stays IDLE, A_OUT/B_OUT hold their last value and outputs are unchanged.
- APPLY (1 cycle):
  - A_OUT/B_OUT = vector[index]; BUSY=1; settle count loaded with SETTLE.
  - Next state is WAIT if SETTLE>0, else SAMPLE.
- WAIT: count decrements each cycle; it lasts exactly SETTLE cycles, then SAMPLE.
- SAMPLE (1 cycle):
  - mismatch = Y_IN XOR expected bits for the current vector.
  - FAIL_MASK |= mismatch.
  - If mismatch is nonzero and no earlier mismatch occurred in this run, FAIL_VEC = current {A,B}.
  - index==3 goes to FINISH; otherwise index+1 and APPLY.
- FINISH (1 cycle): DONE=1; BUSY=0; PASS=(FAIL_MASK==0, including the final sample); next state IDLE.
- Latency: START seen in cycle 0 gives DONE high in cycle 1+4*(SETTLE+2). With SETTLE=2 this is cycle 17; with SETTLE=0 it is cycle 9.
- START while BUSY or in FINISH is ignored (no queueing).
- START held high continuously re-launches a run one cycle after each FINISH.
- TT changes during a run have no effect (the latched copy is used). Y_IN is only observed in SAMPLE.
- A_OUT/B_OUT remain at 10 after a run until the next APPLY.
- Settle counter saturates at 0, never wraps.
- Index wraps 3→0 only via IDLE.

Decomposition:
- Shared package gate_bist_pkg holds:
  - state enum (IDLE, APPLY, WAIT, SAMPLE, FINISH);
  - Gray vector constant table VEC[0:3] = {00, 01, 11, 10};
  - truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_NAND=4'b0111, TT_XOR=4'b0110.
- One sub-module is natural: gate_bist_settle_cnt. It is a loadable down-counter (LOAD, VAL[CW-1:0], ZERO) with async active-low reset, reused for other timing-test blocks.

Test Plan:
- SETTLE=2; cells modelled as AND, OR, NAND, XOR; TT={XOR,NAND,OR,AND}; pulse START → A_OUT,B_OUT step 00,01,11,10; DONE at cycle 17; PASS=1, FAIL_MASK=0000, FAIL_VEC=00.
- Cell 1 stuck-at-0 (OR model forced 0), same TT → FAIL_MASK=0010, FAIL_VEC=01, PASS=0, DONE still at cycle 17.
- SETTLE=0; all correct → DONE at cycle 9; WAIT never entered; each vector held exactly 2 cycles.
- START pulsed again at cycles 3 and 10 of a run → ignored: single DONE at 17, BUSY continuous cycles 1–16.
- R driven low at cycle 6 mid-run → outputs all 0 asynchronously, state IDLE, no DONE. After R release, START → full normal run.
- TT changed to all-zero at cycle 5 of a passing run → PASS=1 (latched TT used). The next run uses the new TT → FAIL_MASK shows every cell with any 1 in its table.
